stopwatch_ctrl: RTL and testbench
=================================

# stopwatch_ctrl

Control sequencer for the stopwatch counter core. It debounces the two front-panel keys (start/stop, lap/reset) and runs the stopwatch state machine. It also generates the 10 ms count-enable tick and the active-low clear for the BCD counter core, and drives the display bus with either live counter values or a frozen lap snapshot. It sits between the raw key pins and the counter core; the display driver consumes its outputs.

## Interface
- DIV, default 100000: clk_core cycles per count tick (100 Hz at 10 MHz).
- DB_CYCLES, default 20000: consecutive stable synchronized samples required to accept a key level change.
- clk_core  in  1  core clock.
- rst  in  1  reset, asynchronous, active-low.
- key_ss  in  1  raw start/stop key, active-high, asynchronous to clk_core.
- key_lr  in  1  raw lap/reset key, active-high, asynchronous to clk_core.
- min_i  in  8  BCD minutes from counter core.
- sec_i  in  8  BCD seconds from counter core.
- ms_10_i  in  8  BCD 10 ms units from counter core.
- cnt_en  out  1  one-cycle count tick to counter core.
- cnt_clr_n  out  1  active-low clear to counter core.
- disp_min  out  8  displayed minutes.
- disp_sec  out  8  displayed seconds.
- disp_ms  out  8  displayed 10 ms units.
- running  out  1  high in RUN and LAP.
- lap_hold  out  1  high in LAP (display frozen).

## Operation
- Debounce, per key:
  - 2-FF synchronizer.
  - Stability counter: the debounced level takes the synchronized value after DB_CYCLES consecutive cycles of disagreement. Any agreement resets the counter.
  - Press event = debounced 0→1 edge, one cycle wide. Release generates no event.
- FSM states: IDLE (zeroed, stopped), RUN, LAP (counting, display frozen), STOP (paused).
  - IDLE: ss → RUN. lr → stay IDLE and issue a clear pulse.
  - RUN: ss → STOP. lr → LAP and latch min_i/sec_i/ms_10_i into the lap registers in the same cycle.
  - LAP: ss → STOP, display goes live. lr → RUN, display goes live.
  - STOP: ss → RUN. lr → IDLE and issue a clear pulse.
- Simultaneous ss and lr events in one cycle: ss wins and lr is discarded.
- Prescaler, width ceil(log2(DIV)):
  - Increments only in RUN/LAP.
  - At DIV-1 it wraps to 0 and asserts cnt_en for that one cycle.
  - Holds its value in STOP, so a resume preserves the partial tick.
  - Forced to 0 on entry to IDLE.
- cnt_en is never asserted in IDLE or STOP, or in any cycle where cnt_clr_n is low.
- Display:
  - In LAP, disp_* show the lap registers.
  - Otherwise disp_* are the registered copy of min_i/sec_i/ms_10_i.
- Reset values:
  - state IDLE, prescaler 0, debounced levels 0, lap registers 0.
  - cnt_en 0, cnt_clr_n 0, disp_* 8'h00, running 0, lap_hold 0.
- Reset mid-operation: all of the above apply asynchronously. cnt_clr_n stays low for the whole reset assertion and rises on the first clk_core edge after rst deasserts.

## Timing
- Raw key stable change → press event: DB_CYCLES+3 cycles (2 sync, DB_CYCLES qualify, 1 edge detect).
- Press event at cycle N → state, running and lap_hold updated at the edge ending cycle N. Lap registers are written at that same edge.
- Clear: cnt_clr_n is low for exactly cycle N+1, once per qualifying lr event.
- First cnt_en after IDLE→RUN: DIV cycles after the state change.
- Resume from STOP: the next tick arrives after the remaining (DIV-1-held_count) cycles plus 1.
- disp_* follow the counter inputs with 1 cycle latency.
- Frozen values appear on disp_* the cycle after LAP entry.
- Live display resumes the cycle after LAP exit.
- Key bounce shorter than DB_CYCLES produces no event. A held key produces exactly one event.

## Test plan
All scenarios use DIV=4, DB_CYCLES=3.
- Reset release → cnt_clr_n 0 until the first edge then 1. running=0, disp_*=00, no cnt_en for 50 cycles.
- key_ss pulse held 10 cycles → one event, state RUN. cnt_en pulses every 4 cycles, first one 4 cycles after the state change. Release yields no event.
- key_ss toggling 1-0-1-0 at 2-cycle intervals, then held → one event only, at DB_CYCLES+3 after the final rise.
- RUN with min_i/sec_i/ms_10_i = 01/23/45, press lr → disp_*=01/23/45 frozen while inputs change and cnt_en continues. Press lr again → display live, lap_hold=0.
- RUN, press ss after 2 prescaler counts, wait 20 cycles, press ss → no cnt_en while stopped. Next cnt_en arrives 2 cycles after resume.
- STOP, press lr → cnt_clr_n low exactly 1 cycle, state IDLE, prescaler 0. ss and lr released into the same cycle → RUN only, no clear.

Source files
------------

// File: rtl/stopwatch_ctrl.sv
// Stopwatch sequencer: key debounce, run/lap/stop FSM, 10 ms tick prescaler,
// counter-core clear and live/frozen display selection.
//
// state  | meaning
// -------+-----------------------------------------------
// IDLE   | zeroed and stopped, prescaler held at 0
// RUN    | counting, display live
// LAP    | counting, display frozen on lap registers
// STOP   | paused, prescaler holds its partial count
module stopwatch_ctrl #(
  parameter int unsigned DIV       = 100000,
  parameter int unsigned DB_CYCLES = 20000
) (
  input  logic       clk_core,
  input  logic       rst,
  input  logic       key_ss,
  input  logic       key_lr,
  input  logic [7:0] min_i,
  input  logic [7:0] sec_i,
  input  logic [7:0] ms_10_i,
  output logic       cnt_en,
  output logic       cnt_clr_n,
  output logic [7:0] disp_min,
  output logic [7:0] disp_sec,
  output logic [7:0] disp_ms,
  output logic       running,
  output logic       lap_hold
);

  localparam int PW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int DBW = (DB_CYCLES > 1) ? $clog2(DB_CYCLES + 1) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_LAP  = 2'd2,
    S_STOP = 2'd3
  } state_t;

  state_t state_q, state_d;

  logic [1:0]          key_raw;
  logic [1:0]          sync1_q, sync2_q;
  logic [1:0]          db_q, db_prev_q;
  logic [1:0][DBW-1:0] db_cnt_q;
  logic [1:0]          press;
  logic                ss_evt, lr_evt;

  logic                clr_req, lap_load;
  logic                count_ok;
  logic [PW-1:0]       presc_q;
  logic                cnt_en_q, clr_n_q;

  logic [7:0]          live_min_q, live_sec_q, live_ms_q;
  logic [7:0]          lap_min_q, lap_sec_q, lap_ms_q;

  assign key_raw = {key_lr, key_ss};

  // Level is accepted only after DB_CYCLES consecutive disagreeing samples.
  always_ff @(posedge clk_core or negedge rst) begin
    if (!rst) begin
      sync1_q   <= '0;
      sync2_q   <= '0;
      db_q      <= '0;
      db_prev_q <= '0;
      db_cnt_q  <= '0;
    end else begin
      sync1_q   <= key_raw;
      sync2_q   <= sync1_q;
      db_prev_q <= db_q;
      for (int k = 0; k < 2; k++) begin
        if (sync2_q[k] == db_q[k]) begin
          db_cnt_q[k] <= '0;
        end else if (db_cnt_q[k] == DBW'(DB_CYCLES - 1)) begin
          db_q[k]     <= sync2_q[k];
          db_cnt_q[k] <= '0;
        end else begin
          db_cnt_q[k] <= db_cnt_q[k] + 1'b1;
        end
      end
    end
  end

  assign press  = db_q & ~db_prev_q;
  assign ss_evt = press[0];
  assign lr_evt = press[1] & ~press[0];

  always_ff @(posedge clk_core or negedge rst) begin
    if (!rst) state_q <= S_IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    clr_req  = 1'b0;
    lap_load = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (ss_evt)      state_d = S_RUN;
        else if (lr_evt) clr_req = 1'b1;
      end
      S_RUN: begin
        if (ss_evt) begin
          state_d = S_STOP;
        end else if (lr_evt) begin
          state_d  = S_LAP;
          lap_load = 1'b1;
        end
      end
      S_LAP: begin
        if (ss_evt)      state_d = S_STOP;
        else if (lr_evt) state_d = S_RUN;
      end
      S_STOP: begin
        if (ss_evt) begin
          state_d = S_RUN;
        end else if (lr_evt) begin
          state_d = S_IDLE;
          clr_req = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    running  = (state_q == S_RUN) || (state_q == S_LAP);
    lap_hold = (state_q == S_LAP);
    if (lap_hold) begin
      disp_min = lap_min_q;
      disp_sec = lap_sec_q;
      disp_ms  = lap_ms_q;
    end else begin
      disp_min = live_min_q;
      disp_sec = live_sec_q;
      disp_ms  = live_ms_q;
    end
  end

  // Counting is suppressed on the edge that leaves RUN/LAP so STOP holds
  // exactly the partial count and no tick lands in STOP.
  assign count_ok = ((state_q == S_RUN) || (state_q == S_LAP)) &&
                    ((state_d == S_RUN) || (state_d == S_LAP));

  always_ff @(posedge clk_core or negedge rst) begin
    if (!rst) begin
      presc_q  <= '0;
      cnt_en_q <= 1'b0;
    end else begin
      cnt_en_q <= 1'b0;
      if (state_d == S_IDLE) begin
        presc_q <= '0;
      end else if (count_ok) begin
        if (presc_q == PW'(DIV - 1)) begin
          presc_q  <= '0;
          cnt_en_q <= 1'b1;
        end else begin
          presc_q <= presc_q + 1'b1;
        end
      end
    end
  end

  // Low throughout reset, released on the first edge afterwards.
  always_ff @(posedge clk_core or negedge rst) begin
    if (!rst) clr_n_q <= 1'b0;
    else      clr_n_q <= ~clr_req;
  end

  always_ff @(posedge clk_core or negedge rst) begin
    if (!rst) begin
      live_min_q <= '0;
      live_sec_q <= '0;
      live_ms_q  <= '0;
      lap_min_q  <= '0;
      lap_sec_q  <= '0;
      lap_ms_q   <= '0;
    end else begin
      live_min_q <= min_i;
      live_sec_q <= sec_i;
      live_ms_q  <= ms_10_i;
      if (lap_load) begin
        lap_min_q <= min_i;
        lap_sec_q <= sec_i;
        lap_ms_q  <= ms_10_i;
      end
    end
  end

  assign cnt_en    = cnt_en_q;
  assign cnt_clr_n = clr_n_q;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Self-checking bench for stopwatch_ctrl with DIV=4, DB_CYCLES=3.
// Expected tick cycles and display values are queued when stimulus is driven.
module tb_stopwatch_ctrl;

  localparam int DIV = 4;
  localparam int DB  = 3;
  localparam int LAT = DB + 3;

  logic       clk_core = 1'b0;
  logic       rst      = 1'b0;
  logic       key_ss   = 1'b0;
  logic       key_lr   = 1'b0;
  logic [7:0] min_i    = 8'h00;
  logic [7:0] sec_i    = 8'h00;
  logic [7:0] ms_10_i  = 8'h00;
  logic       cnt_en, cnt_clr_n, running, lap_hold;
  logic [7:0] disp_min, disp_sec, disp_ms;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int tick_log[$];
  int clr_log[$];
  logic [23:0] disp_q[$];

  stopwatch_ctrl #(.DIV(DIV), .DB_CYCLES(DB)) dut (
    .clk_core (clk_core),
    .rst      (rst),
    .key_ss   (key_ss),
    .key_lr   (key_lr),
    .min_i    (min_i),
    .sec_i    (sec_i),
    .ms_10_i  (ms_10_i),
    .cnt_en   (cnt_en),
    .cnt_clr_n(cnt_clr_n),
    .disp_min (disp_min),
    .disp_sec (disp_sec),
    .disp_ms  (disp_ms),
    .running  (running),
    .lap_hold (lap_hold)
  );

  always #5 clk_core = ~clk_core;

  always @(posedge clk_core) cyc <= cyc + 1;

  // Observation log, sampled shortly after each active edge.
  always @(posedge clk_core) begin
    #2;
    if (rst) begin
      if (cnt_en)     tick_log.push_back(cyc);
      if (!cnt_clr_n) clr_log.push_back(cyc);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired at cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

  task automatic wait_until(input int c);
    while (cyc < c) @(negedge clk_core);
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk_core);
    checks++;
    if ({cnt_clr_n, cnt_en, running, lap_hold} !== 4'b0000) begin
      failures++;
      $display("FAIL reset_ctrl got clr_n/en/run/lap=%b exp=0000",
               {cnt_clr_n, cnt_en, running, lap_hold});
    end
    checks++;
    if ({disp_min, disp_sec, disp_ms} !== 24'h000000) begin
      failures++;
      $display("FAIL reset_disp got=%h exp=000000", {disp_min, disp_sec, disp_ms});
    end
    rst = 1'b1;
    #1;
    checks++;
    if (cnt_clr_n !== 1'b0) begin
      failures++;
      $display("FAIL reset_clr_before_edge got=%b exp=0", cnt_clr_n);
    end
    @(negedge clk_core);
    checks++;
    if (cnt_clr_n !== 1'b1) begin
      failures++;
      $display("FAIL reset_clr_after_edge got=%b exp=1", cnt_clr_n);
    end
    tick_log.delete();
    repeat (50) @(negedge clk_core);
    checks++;
    if (tick_log.size() != 0 || running !== 1'b0) begin
      failures++;
      $display("FAIL reset_idle ticks=%0d running=%b exp ticks=0 running=0",
               tick_log.size(), running);
    end
  endtask

  task automatic test_start();
    int t0, r, seen, idx, e, got;
    int exp_q[$];
    t0 = cyc;
    tick_log.delete();
    key_ss = 1'b1;
    seen = 0;
    for (int i = 1; i <= 20 && seen == 0; i++) begin
      @(negedge clk_core);
      if (cyc >= t0 + 10) key_ss = 1'b0;
      if (running === 1'b1) seen = i;
    end
    checks++;
    if (seen != LAT) begin
      failures++;
      $display("FAIL start_latency got=%0d exp=%0d", seen, LAT);
    end
    wait_until(t0 + 10);
    key_ss = 1'b0;
    r = t0 + LAT;
    for (int k = 1; k <= 5; k++) exp_q.push_back(r + DIV * k);
    wait_until(r + 21);
    checks++;
    if (tick_log.size() != exp_q.size()) begin
      failures++;
      $display("FAIL start_tick_count got=%0d exp=%0d", tick_log.size(), exp_q.size());
    end
    idx = 0;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      got = (idx < tick_log.size()) ? tick_log[idx] : -1;
      checks++;
      if (got != e) begin
        failures++;
        $display("FAIL start_tick_cycle idx=%0d got=%0d exp=%0d", idx, got, e);
      end
      idx++;
    end
    checks++;
    if (running !== 1'b1) begin
      failures++;
      $display("FAIL start_release_no_event running=%b exp=1", running);
    end
  endtask

  task automatic test_bounce();
    int c0, fall_at;
    c0 = cyc;
    fall_at = -1;
    key_ss = 1'b1;
    for (int k = c0 + 1; k <= c0 + 33; k++) begin
      @(negedge clk_core);
      if (running === 1'b0 && fall_at < 0) fall_at = k;
      if (k == c0 + 2 || k == c0 + 6 || k == c0 + 23) key_ss = 1'b0;
      if (k == c0 + 4 || k == c0 + 8) key_ss = 1'b1;
    end
    checks++;
    if (fall_at != c0 + 8 + LAT) begin
      failures++;
      $display("FAIL bounce_event_cycle got=%0d exp=%0d", fall_at, c0 + 8 + LAT);
    end
    checks++;
    if (running !== 1'b0) begin
      failures++;
      $display("FAIL bounce_single_event running=%b exp=0", running);
    end
  endtask

  task automatic test_clear();
    int t0;
    t0 = cyc;
    clr_log.delete();
    key_lr = 1'b1;
    wait_until(t0 + 10);
    key_lr = 1'b0;
    wait_until(t0 + 20);
    checks++;
    if (clr_log.size() != 1) begin
      failures++;
      $display("FAIL clear_pulse_width got=%0d exp=1", clr_log.size());
    end else begin
      checks++;
      if (clr_log[0] != t0 + LAT) begin
        failures++;
        $display("FAIL clear_pulse_cycle got=%0d exp=%0d", clr_log[0], t0 + LAT);
      end
    end
    checks++;
    if (running !== 1'b0 || cnt_clr_n !== 1'b1) begin
      failures++;
      $display("FAIL clear_idle running=%b clr_n=%b exp 0 1", running, cnt_clr_n);
    end
  endtask

  task automatic test_resume();
    int t0, r, idx, e, got;
    int exp_q[$];
    t0 = cyc;
    r = t0 + LAT;
    tick_log.delete();
    // Stop lands with two counts held; resume must tick two cycles later.
    for (int k = 1; k <= 4; k++) exp_q.push_back(r + DIV * k);
    exp_q.push_back(t0 + 45 + LAT + 2);
    exp_q.push_back(t0 + 45 + LAT + 2 + DIV);
    key_ss = 1'b1;
    wait_until(t0 + 10); key_ss = 1'b0;
    wait_until(t0 + 19); key_ss = 1'b1;
    wait_until(t0 + 29); key_ss = 1'b0;
    wait_until(t0 + 40);
    checks++;
    if (running !== 1'b0) begin
      failures++;
      $display("FAIL resume_stopped running=%b exp=0", running);
    end
    wait_until(t0 + 45); key_ss = 1'b1;
    wait_until(t0 + 55); key_ss = 1'b0;
    wait_until(t0 + 60);
    checks++;
    if (tick_log.size() != exp_q.size()) begin
      failures++;
      $display("FAIL resume_tick_count got=%0d exp=%0d", tick_log.size(), exp_q.size());
    end
    idx = 0;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      got = (idx < tick_log.size()) ? tick_log[idx] : -1;
      checks++;
      if (got != e) begin
        failures++;
        $display("FAIL resume_tick_cycle idx=%0d got=%0d exp=%0d", idx, got, e);
      end
      idx++;
    end
  endtask

  task automatic test_lap();
    int c, nt;
    logic [23:0] lapv, drv, expv, got;
    logic exp_lh;
    lapv = 24'h012345;
    c = cyc;
    tick_log.delete();
    disp_q.delete();
    {min_i, sec_i, ms_10_i} = lapv;
    disp_q.push_back(lapv);
    key_lr = 1'b1;
    for (int k = c + 1; k <= c + 34; k++) begin
      @(negedge clk_core);
      got  = {disp_min, disp_sec, disp_ms};
      expv = disp_q.pop_front();
      checks++;
      if (got !== expv) begin
        failures++;
        $display("FAIL lap_disp cyc=%0d got=%h exp=%h", k, got, expv);
      end
      exp_lh = (k >= c + LAT) && (k <= c + 20 + LAT - 1);
      checks++;
      if (lap_hold !== exp_lh) begin
        failures++;
        $display("FAIL lap_hold cyc=%0d got=%b exp=%b", k, lap_hold, exp_lh);
      end
      if (k == c + 10 || k == c + 30) key_lr = 1'b0;
      if (k == c + 20) key_lr = 1'b1;
      if (k + 1 <= c + LAT) drv = lapv;
      else drv = {8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
                  8'($urandom_range(0, 255))};
      {min_i, sec_i, ms_10_i} = drv;
      disp_q.push_back(((k + 1 >= c + LAT) && (k + 1 <= c + 20 + LAT - 1)) ? lapv : drv);
    end
    nt = 0;
    foreach (tick_log[i]) if (tick_log[i] >= c + 1 && tick_log[i] <= c + 32) nt++;
    checks++;
    if (nt != 32 / DIV) begin
      failures++;
      $display("FAIL lap_ticks_continue got=%0d exp=%0d", nt, 32 / DIV);
    end
    repeat (6) @(negedge clk_core);
  endtask

  task automatic test_simultaneous();
    int t0, t1;
    t0 = cyc;
    key_ss = 1'b1;
    wait_until(t0 + 10); key_ss = 1'b0;
    wait_until(t0 + 20);
    checks++;
    if (running !== 1'b0) begin
      failures++;
      $display("FAIL simul_pre_stop running=%b exp=0", running);
    end
    t1 = cyc;
    clr_log.delete();
    key_ss = 1'b1;
    key_lr = 1'b1;
    wait_until(t1 + LAT);
    checks++;
    if (running !== 1'b1) begin
      failures++;
      $display("FAIL simul_ss_wins running=%b exp=1", running);
    end
    wait_until(t1 + 10);
    key_ss = 1'b0;
    key_lr = 1'b0;
    wait_until(t1 + 20);
    checks++;
    if (clr_log.size() != 0 || running !== 1'b1 || lap_hold !== 1'b0) begin
      failures++;
      $display("FAIL simul_lr_discarded clears=%0d running=%b lap=%b exp 0 1 0",
               clr_log.size(), running, lap_hold);
    end
  endtask

  task automatic test_async_reset();
    int bad;
    {min_i, sec_i, ms_10_i} = 24'h595999;
    repeat (2) @(negedge clk_core);
    #2 rst = 1'b0;
    #1;
    checks++;
    if ({cnt_clr_n, cnt_en, running, lap_hold} !== 4'b0000 ||
        {disp_min, disp_sec, disp_ms} !== 24'h000000) begin
      failures++;
      $display("FAIL async_reset got ctrl=%b disp=%h exp ctrl=0000 disp=000000",
               {cnt_clr_n, cnt_en, running, lap_hold}, {disp_min, disp_sec, disp_ms});
    end
    bad = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_core);
      if (cnt_clr_n !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL async_reset_clr_held high_cycles=%0d exp=0", bad);
    end
    rst = 1'b1;
    #1;
    checks++;
    if (cnt_clr_n !== 1'b0) begin
      failures++;
      $display("FAIL async_reset_clr_release got=%b exp=0", cnt_clr_n);
    end
    @(negedge clk_core);
    checks++;
    if (cnt_clr_n !== 1'b1) begin
      failures++;
      $display("FAIL async_reset_clr_rise got=%b exp=1", cnt_clr_n);
    end
    repeat (8) @(negedge clk_core);
    checks++;
    if (running !== 1'b0) begin
      failures++;
      $display("FAIL async_reset_idle running=%b exp=0", running);
    end
  endtask

  initial begin
    test_reset();
    test_start();
    test_bounce();
    test_clear();
    test_resume();
    test_lap();
    test_simultaneous();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
